// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM for a shared-memory datapath.
// Sequences fetch/decode/execute, handshakes memory via req/ready, counts retired instructions.
module mips_multicycle_ctrl #(
   parameter int unsigned CNT_W       = 32,
   parameter bit          ENABLE_ADDI = 1'b1,
   parameter bit          ENABLE_JUMP = 1'b1
) (
   input  logic             i_clk_w,
   input  logic             i_rst_w,
   input  logic [5:0]       i_op_w,
   input  logic [5:0]       i_funct_w,
   input  logic             i_zero_w,
   input  logic             i_mem_ready_w,
   output logic             o_mem_req_w,
   output logic             o_iord_w,
   output logic             o_mem_write_w,
   output logic             o_ir_write_w,
   output logic             o_mem_to_reg_w,
   output logic             o_reg_dst_w,
   output logic             o_reg_write_w,
   output logic             o_alu_src_a_w,
   output logic [1:0]       o_alu_src_b_w,
   output logic [1:0]       o_pc_src_w,
   output logic             o_pc_en_w,
   output logic [2:0]       o_alu_control_w,
   output logic [3:0]       o_state_w,
   output logic             o_illegal_w,
   output logic [CNT_W-1:0] o_retired_cnt_w
);

   localparam logic [3:0] StFetch  = 4'd0;
   localparam logic [3:0] StDecode = 4'd1;
   localparam logic [3:0] StMemAdr = 4'd2;
   localparam logic [3:0] StMemRd  = 4'd3;
   localparam logic [3:0] StMemWb  = 4'd4;
   localparam logic [3:0] StMemWr  = 4'd5;
   localparam logic [3:0] StExec   = 4'd6;
   localparam logic [3:0] StAluWb  = 4'd7;
   localparam logic [3:0] StBranch = 4'd8;
   localparam logic [3:0] StAddiEx = 4'd9;
   localparam logic [3:0] StAddiWb = 4'd10;
   localparam logic [3:0] StJump   = 4'd11;

   localparam logic [5:0] OpR    = 6'b000000;
   localparam logic [5:0] OpLw   = 6'b100011;
   localparam logic [5:0] OpSw   = 6'b101011;
   localparam logic [5:0] OpBeq  = 6'b000100;
   localparam logic [5:0] OpAddi = 6'b001000;
   localparam logic [5:0] OpJ    = 6'b000010;

   logic [3:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic             retire;
   logic             illegal;
   logic             funct_ok;

   logic       mem_req, iord, mem_write, ir_write, mem_to_reg, reg_dst, reg_write;
   logic       alu_src_a, branch, pc_write;
   logic [1:0] alu_src_b, pc_src, alu_op;

   always_comb begin
      unique case (i_funct_w)
         6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: funct_ok = 1'b1;
         default:                                              funct_ok = 1'b0;
      endcase
   end

   // Moore control decode; only FETCH's ir_write/pc_write depend on ready.
   always_comb begin
      mem_req    = 1'b0;
      iord       = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      mem_to_reg = 1'b0;
      reg_dst    = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      pc_src     = 2'b00;
      branch     = 1'b0;
      pc_write   = 1'b0;
      case (state_q)
         StFetch: begin
            mem_req   = 1'b1;
            alu_src_b = 2'b01;
            if (i_mem_ready_w) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
            end
         end
         StDecode: alu_src_b = 2'b11;
         StMemAdr, StAddiEx: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         StMemRd: begin
            mem_req = 1'b1;
            iord    = 1'b1;
         end
         StMemWr: begin
            mem_req   = 1'b1;
            iord      = 1'b1;
            mem_write = 1'b1;
         end
         StMemWb: begin
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
         end
         StExec: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
         end
         StAluWb: begin
            reg_dst   = 1'b1;
            reg_write = 1'b1;
         end
         StBranch: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b01;
            branch    = 1'b1;
            pc_src    = 2'b01;
         end
         StAddiWb: reg_write = 1'b1;
         StJump: begin
            pc_src   = 2'b10;
            pc_write = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d = StFetch;
      illegal = 1'b0;
      retire  = 1'b0;
      case (state_q)
         StFetch:  state_d = i_mem_ready_w ? StDecode : StFetch;
         StDecode: begin
            if (i_op_w == OpLw || i_op_w == OpSw)        state_d = StMemAdr;
            else if (i_op_w == OpR && funct_ok)          state_d = StExec;
            else if (i_op_w == OpBeq)                    state_d = StBranch;
            else if (i_op_w == OpAddi && ENABLE_ADDI)    state_d = StAddiEx;
            else if (i_op_w == OpJ && ENABLE_JUMP)       state_d = StJump;
            else                                         illegal = 1'b1;
         end
         StMemAdr: state_d = (i_op_w == OpSw) ? StMemWr : StMemRd;
         StMemRd:  state_d = i_mem_ready_w ? StMemWb : StMemRd;
         StMemWr: begin
            state_d = i_mem_ready_w ? StFetch : StMemWr;
            retire  = i_mem_ready_w;
         end
         StExec:   state_d = StAluWb;
         StAddiEx: state_d = StAddiWb;
         StMemWb, StAluWb, StBranch, StAddiWb, StJump: retire = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      unique case (alu_op)
         2'b00: o_alu_control_w = 3'b010;
         2'b01: o_alu_control_w = 3'b110;
         2'b10: begin
            case (i_funct_w)
               6'b100010: o_alu_control_w = 3'b110;
               6'b100100: o_alu_control_w = 3'b000;
               6'b100101: o_alu_control_w = 3'b001;
               6'b101010: o_alu_control_w = 3'b111;
               default:   o_alu_control_w = 3'b010;
            endcase
         end
         default: o_alu_control_w = 3'b010;
      endcase
   end

   always_ff @(posedge i_clk_w or negedge i_rst_w) begin
      if (!i_rst_w) begin
         state_q <= StFetch;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (retire) cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   // Side-effecting strobes are gated by reset so they drop the instant it asserts.
   assign o_mem_req_w     = mem_req & i_rst_w;
   assign o_mem_write_w   = mem_write & i_rst_w;
   assign o_ir_write_w    = ir_write & i_rst_w;
   assign o_reg_write_w   = reg_write & i_rst_w;
   assign o_pc_en_w       = (pc_write | (branch & i_zero_w)) & i_rst_w;
   assign o_illegal_w     = illegal & i_rst_w;
   assign o_iord_w        = iord;
   assign o_mem_to_reg_w  = mem_to_reg;
   assign o_reg_dst_w     = reg_dst;
   assign o_alu_src_a_w   = alu_src_a;
   assign o_alu_src_b_w   = alu_src_b;
   assign o_pc_src_w      = pc_src;
   assign o_state_w       = state_q;
   assign o_retired_cnt_w = cnt_q;

endmodule
